bus_timer: RTL and testbench

//  Memory-mapped programmable down-counter timer on the proc bus (ADDR/DOUT/W in, read data out).

---
 rtl/bus_timer.sv | 130 +++++++++++++
 tb/tb_bus_timer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_timer.sv
// Memory-mapped prescaled down-counter timer on the proc bus.
// Four registers alias through a 4 KB page; read data is registered (one-cycle latency).
module bus_timer #(
    parameter logic [3:0]  BASE     = 4'h2,
    parameter int unsigned PRESCALE = 50000
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [15:0] ADDR,
    input  logic [15:0] DOUT,
    input  logic        W,
    output logic        Sel,
    output logic [15:0] Q,
    output logic        Done
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [15:0]   r_load;
    logic [15:0]   r_count;
    logic          r_en;
    logic          r_ar;
    logic          r_done;
    logic [PW-1:0] r_pre;
    logic [15:0]   r_q;

    logic [15:0]   w_load_nxt;
    logic [15:0]   w_count_nxt;
    logic          w_en_nxt;
    logic          w_ar_nxt;
    logic          w_done_nxt;
    logic [PW-1:0] w_pre_nxt;
    logic [15:0]   w_q_nxt;

    logic          w_sel;
    logic          w_wr;
    logic          w_wr_load;
    logic          w_wr_ctrl;
    logic          w_wr_status;
    logic          w_tick;
    logic [15:0]   w_rdata;
    logic          w_unused_addr;

    assign w_sel         = (ADDR[15:12] == BASE);
    assign w_wr          = W & w_sel;
    assign w_wr_load     = w_wr && (ADDR[1:0] == 2'd0);
    assign w_wr_ctrl     = w_wr && (ADDR[1:0] == 2'd2);
    assign w_wr_status   = w_wr && (ADDR[1:0] == 2'd3);
    assign w_tick        = r_en && (r_pre == PRE_LAST);
    assign w_unused_addr = ^ADDR[11:2];

    always_comb begin
        w_rdata = 16'h0000;
        unique case (ADDR[1:0])
            2'd0: w_rdata = r_load;
            2'd1: w_rdata = r_count;
            2'd2: w_rdata = {14'b0, r_ar, r_en};
            2'd3: w_rdata = {15'b0, r_done};
            default: w_rdata = 16'h0000;
        endcase
    end

    always_comb begin
        w_load_nxt  = r_load;
        w_count_nxt = r_count;
        w_en_nxt    = r_en;
        w_ar_nxt    = r_ar;
        w_done_nxt  = r_done;
        w_pre_nxt   = r_pre;
        w_q_nxt     = r_q;

        if (w_wr_load || !r_en || w_tick) begin
            w_pre_nxt = '0;
        end else begin
            w_pre_nxt = r_pre + 1'b1;
        end

        if (w_wr_ctrl) begin
            w_en_nxt = DOUT[0];
            w_ar_nxt = DOUT[1];
        end

        if (w_wr_status && DOUT[0]) begin
            w_done_nxt = 1'b0;
        end

        // A LOAD write swallows a coincident tick, including its DONE set.
        if (w_wr_load) begin
            w_load_nxt  = DOUT;
            w_count_nxt = DOUT;
        end else if (w_tick) begin
            if (r_count > 16'd1) begin
                w_count_nxt = r_count - 16'd1;
            end else if (r_count == 16'd1) begin
                w_done_nxt  = 1'b1;
                w_count_nxt = r_ar ? r_load : 16'd0;
            end
        end

        if (w_sel) begin
            w_q_nxt = w_rdata;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_load  <= 16'h0000;
            r_count <= 16'h0000;
            r_en    <= 1'b0;
            r_ar    <= 1'b0;
            r_done  <= 1'b0;
            r_pre   <= '0;
            r_q     <= 16'h0000;
        end else begin
            r_load  <= w_load_nxt;
            r_count <= w_count_nxt;
            r_en    <= w_en_nxt;
            r_ar    <= w_ar_nxt;
            r_done  <= w_done_nxt;
            r_pre   <= w_pre_nxt;
            r_q     <= w_q_nxt;
        end
    end

    assign Sel  = w_sel;
    assign Q    = r_q;
    assign Done = r_done;

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: one instance with PRESCALE=4 on page 2,
// one with PRESCALE=2 on page 5, sharing the bus.
module tb_bus_timer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr;
    logic [15:0] dout;
    logic        w;
    logic        sel4, sel2;
    logic [15:0] q4, q2;
    logic        done4, done2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_timer #(.BASE(4'h2), .PRESCALE(4)) u_dut4 (
        .Clock (clk),
        .Resetn(rst_n),
        .ADDR  (addr),
        .DOUT  (dout),
        .W     (w),
        .Sel   (sel4),
        .Q     (q4),
        .Done  (done4)
    );

    bus_timer #(.BASE(4'h5), .PRESCALE(2)) u_dut2 (
        .Clock (clk),
        .Resetn(rst_n),
        .ADDR  (addr),
        .DOUT  (dout),
        .W     (w),
        .Sel   (sel2),
        .Q     (q2),
        .Done  (done2)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addr = a;
        dout = d;
        w    = 1'b1;
        @(negedge clk);
        w    = 1'b0;
        addr = 16'h0000;
        dout = 16'h0000;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] v);
        addr = a;
        w    = 1'b0;
        @(negedge clk);
        v    = (a[15:12] == 4'h5) ? q2 : q4;
        addr = 16'h0000;
    endtask

    task automatic wait_done(input bit use2, input int budget, output int t);
        int n = 0;
        while (((use2 ? done2 : done4) == 1'b0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_seen", {15'b0, (use2 ? done2 : done4)}, 16'h0001);
        t = cyc;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        logic [15:0] v;
        int t0, t1, t2;

        rst_n = 1'b0;
        addr  = 16'h0000;
        dout  = 16'h0000;
        w     = 1'b0;
        #1;
        check_eq("rst_q4", q4, 16'h0000);
        check_eq("rst_done4", {15'b0, done4}, 16'h0000);
        check_eq("rst_q2", q2, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // One-shot, PRESCALE=4, LOAD=3: DONE 12 cycles after the EN write.
        wr(16'h2000, 16'd3);
        wr(16'h2002, 16'd1);
        t0 = cyc;
        wait_done(1'b0, 100, t1);
        check_eq("oneshot_delay", 16'(t1 - t0), 16'd12);
        rd(16'h2001, v);
        check_eq("oneshot_count0", v, 16'd0);
        repeat (20) @(negedge clk);
        rd(16'h2001, v);
        check_eq("no_wrap", v, 16'd0);
        rd(16'h2003, v);
        check_eq("status_read", v, 16'h0001);
        rd(16'h2002, v);
        check_eq("ctrl_read", v, 16'h0001);

        // Pause: ticks at +4 and +8 leave COUNT=8, then EN cleared.
        wr(16'h2000, 16'd10);
        t0 = cyc;
        wait_until(t0 + 9);
        wr(16'h2002, 16'd0);
        rd(16'h2001, v);
        check_eq("pause_count", v, 16'd8);

        // Other-page writes and COUNT writes must not disturb anything.
        wr(16'h1000, 16'hFFFF);
        wr(16'h1002, 16'h0003);
        wr(16'h2001, 16'h1234);
        addr = 16'h3000;
        #1;
        check_eq("sel_other_page", {15'b0, sel4}, 16'h0000);
        addr = 16'h2000;
        #1;
        check_eq("sel_own_page", {15'b0, sel4}, 16'h0001);
        addr = 16'h0000;
        repeat (120) @(negedge clk);
        rd(16'h2001, v);
        check_eq("pause_hold", v, 16'd8);
        rd(16'h2000, v);
        check_eq("load_kept", v, 16'd10);
        rd(16'h2002, v);
        check_eq("ctrl_kept", v, 16'h0000);

        // Resume: next decrement exactly PRESCALE cycles after the EN write.
        wr(16'h2002, 16'd1);
        addr = 16'h2001;
        repeat (4) @(negedge clk);
        check_eq("resume_early", q4, 16'd8);
        @(negedge clk);
        check_eq("resume_step", q4, 16'd7);
        rd(16'h2FF5, v);
        check_eq("alias_read", v, 16'd7);
        addr = 16'h3000;
        repeat (2) @(negedge clk);
        check_eq("q_hold", q4, 16'd7);
        addr = 16'h0000;

        // Auto-reload, PRESCALE=2, LOAD=2: DONE every 4 cycles.
        wr(16'h5000, 16'd2);
        wr(16'h5002, 16'd3);
        t0 = cyc;
        wait_done(1'b1, 50, t1);
        check_eq("ar_period1", 16'(t1 - t0), 16'd4);
        rd(16'h5001, v);
        check_eq("ar_reload", v, 16'd2);
        wr(16'h5003, 16'h0001);
        check_eq("status_clear", {15'b0, done2}, 16'h0000);
        wait_done(1'b1, 50, t2);
        check_eq("ar_period2", 16'(t2 - t1), 16'd4);

        // Collisions: clear vs set on the same edge, LOAD write on a tick.
        wr(16'h5003, 16'h0001);
        check_eq("clear_again", {15'b0, done2}, 16'h0000);
        wait_until(t2 + 3);
        wr(16'h5003, 16'h0001);
        check_eq("set_beats_clear", {15'b0, done2}, 16'h0001);
        wait_until(t2 + 5);
        wr(16'h5000, 16'd5);
        rd(16'h5001, v);
        check_eq("load_beats_tick", v, 16'd5);

        // Asynchronous reset mid-count.
        rd(16'h2000, v);
        check_eq("load_before_reset", v, 16'd10);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_q4", q4, 16'h0000);
        check_eq("async_done4", {15'b0, done4}, 16'h0000);
        check_eq("async_q2", q2, 16'h0000);
        check_eq("async_done2", {15'b0, done2}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd(16'h2000 + 16'(i), v);
            check_eq("post_reset_reg", v, 16'h0000);
        end
        repeat (10) @(negedge clk);
        rd(16'h5001, v);
        check_eq("post_reset_count2", v, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
